// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide engine that produces the HI/LO results for the multicycle CPU.
// Optional macro MULDIV_EARLY_EXIT_EN: a multiply ends as soon as no multiplier bits remain.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div0_q, div0_d;

    logic               sign_a_s, sign_b_s;
    logic [WIDTH-1:0]   abs_a_s, abs_b_s;
    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     trial_s;
    logic [2*WIDTH-1:0] prod_s, prod_signed_s;
    logic               mult_last_s;
    logic               zero_skip_s;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        logic [WIDTH-1:0] r;
        if (neg) begin
            r = -v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    assign sign_a_s = ~op[0] & a[WIDTH-1];
    assign sign_b_s = ~op[0] & b[WIDTH-1];
    assign abs_a_s  = cond_neg(a, sign_a_s);
    assign abs_b_s  = cond_neg(b, sign_b_s);

    // Upper accumulator half plus the multiplicand when the current multiplier bit is set.
    assign add_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (mag_b_q[0] ? {1'b0, mag_a_q} : {(WIDTH+1){1'b0}});
    assign trial_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, mag_b_q};

`ifdef MULDIV_EARLY_EXIT_EN
    logic [CW-1:0] shamt_s;
    // An early exit leaves the product shifted up by the iterations that were skipped.
    assign shamt_s     = CW'(WIDTH) - count_q;
    assign prod_s      = acc_q >> shamt_s;
    assign mult_last_s = (count_q == CW'(WIDTH - 1)) || (mag_b_q[WIDTH-1:1] == '0);
    assign zero_skip_s = (abs_a_s == '0) || (abs_b_s == '0);
`else
    assign prod_s      = acc_q;
    assign mult_last_s = (count_q == CW'(WIDTH - 1));
    assign zero_skip_s = 1'b0;
`endif

    assign prod_signed_s = neg_res_q ? -prod_s : prod_s;

    // Next-state and datapath update for the IDLE/RUN/FIX/DONE sequence.
    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        acc_d     = acc_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        div0_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    is_div_d  = op[1];
                    neg_res_d = sign_a_s ^ sign_b_s;
                    neg_rem_d = sign_a_s;
                    mag_a_d   = abs_a_s;
                    mag_b_d   = abs_b_s;
                    count_d   = '0;
                    if (op[1]) begin
                        acc_d = {{WIDTH{1'b0}}, abs_a_s};
                    end else begin
                        acc_d = '0;
                    end
                    if (op[1] && (b == '0)) begin
                        state_d = S_DONE;
                        div0_d  = 1'b1;
                    end else if (!op[1] && zero_skip_s) begin
                        state_d = S_FIX;
                        mag_b_d = '0;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    count_d = count_q + CW'(1);
                    if (is_div_q) begin
                        if (!trial_s[WIDTH]) begin
                            acc_d = {trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                        end
                        if (count_q == CW'(WIDTH - 1)) begin
                            state_d = S_FIX;
                        end else begin
                            state_d = S_RUN;
                        end
                    end else begin
                        acc_d   = {add_s, acc_q[WIDTH-1:1]};
                        mag_b_d = mag_b_q >> 1;
                        if (mult_last_s) begin
                            state_d = S_FIX;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        lo_d = cond_neg(acc_q[WIDTH-1:0], neg_res_q);
                        hi_d = cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
                    end else begin
                        lo_d = prod_signed_s[WIDTH-1:0];
                        hi_d = prod_signed_s[2*WIDTH-1:WIDTH];
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            div0_q    <= div0_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: a 32-bit instance for the main behaviour and an 8-bit one for width scaling.
module tb_muldiv_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = 32'h0;
    logic [31:0] b     = 32'h0;
    logic        busy32, done32, div0_32;
    logic [31:0] hi32, lo32;

    logic        start8 = 1'b0;
    logic        flush8 = 1'b0;
    logic [1:0]  op8    = 2'b00;
    logic [7:0]  a8     = 8'h0;
    logic [7:0]  b8     = 8'h0;
    logic        busy8, done8, div0_8;
    logic [7:0]  hi8, lo8;

    int n_checks = 0;
    int n_errors = 0;

`ifdef MULDIV_EARLY_EXIT_EN
    localparam int EXP_NEG_LAT   = 5;
    localparam int EXP_NEG_BUSY  = 4;
    localparam int EXP_ZERO8_LAT = 2;
`else
    localparam int EXP_NEG_LAT   = 34;
    localparam int EXP_NEG_BUSY  = 33;
    localparam int EXP_ZERO8_LAT = 10;
`endif

    muldiv_unit #(.WIDTH(32)) u_dut32 (
        .clock(clock), .reset(reset), .start(start), .op(op), .flush(flush),
        .a(a), .b(b), .busy(busy32), .done(done32), .div0(div0_32), .hi(hi32), .lo(lo32)
    );

    muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clock(clock), .reset(reset), .start(start8), .op(op8), .flush(flush8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .div0(div0_8), .hi(hi8), .lo(lo8)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation on the 32-bit unit and watch it for n_cyc cycles after the start edge.
    task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int n_cyc, input int start_at, input int flush_at,
                         output int first_done, output int n_done, output int busy_cnt,
                         output logic div0_at_done, output logic busy_after_flush);
        @(negedge clock);
        op = o; a = x; b = y; start = 1'b1; flush = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        first_done = -1; n_done = 0; busy_cnt = 0;
        div0_at_done = 1'b0; busy_after_flush = 1'b1;
        for (int c = 1; c <= n_cyc; c++) begin
            if (done32) begin
                if (first_done < 0) begin
                    first_done   = c;
                    div0_at_done = div0_32;
                end
                n_done++;
            end
            if (busy32) busy_cnt++;
            if (c == flush_at + 1) busy_after_flush = busy32;
            start = (c == start_at);
            flush = (c == flush_at);
            @(posedge clock); #1;
        end
        start = 1'b0;
        flush = 1'b0;
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int first_done);
        @(negedge clock);
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clock); #1;
        start8 = 1'b0;
        first_done = -1;
        for (int c = 1; c <= 15; c++) begin
            if (done8 && first_done < 0) first_done = c;
            @(posedge clock); #1;
        end
    endtask

    initial begin
        int   fd, nd, bc;
        logic d0, baf;

        repeat (2) @(posedge clock);
        #1;
        check_value("rst_busy", 64'(busy32), 64'h0);
        check_value("rst_done", 64'(done32), 64'h0);
        check_value("rst_div0", 64'(div0_32), 64'h0);
        check_value("rst_hi",   64'(hi32), 64'h0);
        check_value("rst_lo",   64'(lo32), 64'h0);
        @(negedge clock);
        reset = 1'b1;

        run32(2'b00, 32'hFFFFFFFD, 32'h00000005, 40, -1, -1, fd, nd, bc, d0, baf);
        check_value("mult_lat",   64'(fd), 64'(EXP_NEG_LAT));
        check_value("mult_busy",  64'(bc), 64'(EXP_NEG_BUSY));
        check_value("mult_ndone", 64'(nd), 64'd1);
        check_value("mult_hi",    64'(hi32), 64'hFFFFFFFF);
        check_value("mult_lo",    64'(lo32), 64'hFFFFFFF1);

        run32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 40, -1, -1, fd, nd, bc, d0, baf);
        check_value("multu_lat",  64'(fd), 64'd34);
        check_value("multu_div0", 64'(d0), 64'h0);
        check_value("multu_hi",   64'(hi32), 64'hFFFFFFFE);
        check_value("multu_lo",   64'(lo32), 64'h00000001);

        run32(2'b10, 32'hFFFFFFF9, 32'h00000002, 40, -1, -1, fd, nd, bc, d0, baf);
        check_value("div_lat", 64'(fd), 64'd34);
        check_value("div_lo",  64'(lo32), 64'hFFFFFFFD);
        check_value("div_hi",  64'(hi32), 64'hFFFFFFFF);

        run32(2'b10, 32'h80000000, 32'hFFFFFFFF, 40, -1, -1, fd, nd, bc, d0, baf);
        check_value("divmin_lo",   64'(lo32), 64'h80000000);
        check_value("divmin_hi",   64'(hi32), 64'h00000000);
        check_value("divmin_div0", 64'(d0), 64'h0);

        run32(2'b11, 32'h56781234, 32'h00010000, 40, -1, -1, fd, nd, bc, d0, baf);
        check_value("divu_lo", 64'(lo32), 64'h00005678);
        check_value("divu_hi", 64'(hi32), 64'h00001234);

        run32(2'b11, 32'h00000007, 32'h00000000, 5, -1, -1, fd, nd, bc, d0, baf);
        check_value("div0_lat",   64'(fd), 64'd1);
        check_value("div0_flag",  64'(d0), 64'h1);
        check_value("div0_ndone", 64'(nd), 64'd1);
        check_value("div0_clear", 64'(div0_32), 64'h0);
        check_value("div0_hi",    64'(hi32), 64'h00001234);
        check_value("div0_lo",    64'(lo32), 64'h00005678);

        run32(2'b01, 32'h00000003, 32'h80000001, 45, 10, -1, fd, nd, bc, d0, baf);
        check_value("busystart_lat",   64'(fd), 64'd34);
        check_value("busystart_ndone", 64'(nd), 64'd1);
        check_value("busystart_hi",    64'(hi32), 64'h00000001);
        check_value("busystart_lo",    64'(lo32), 64'h80000003);

        run32(2'b01, 32'h00000005, 32'h80000001, 40, -1, 5, fd, nd, bc, d0, baf);
        check_value("flush_ndone", 64'(nd), 64'd0);
        check_value("flush_busy",  64'(baf), 64'h0);
        check_value("flush_bcnt",  64'(bc), 64'd5);
        check_value("flush_hi",    64'(hi32), 64'h00000001);
        check_value("flush_lo",    64'(lo32), 64'h80000003);

        @(negedge clock);
        op = 2'b00; a = 32'h00000002; b = 32'h00000003; start = 1'b1; flush = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; flush = 1'b0;
        check_value("flushstart_busy", 64'(busy32), 64'h0);

        run32(2'b00, 32'h12345678, 32'h87654321, 19, -1, -1, fd, nd, bc, d0, baf);
        check_value("prerst_busy", 64'(busy32), 64'h1);
        reset = 1'b0;
        #1;
        check_value("midrst_busy", 64'(busy32), 64'h0);
        check_value("midrst_done", 64'(done32), 64'h0);
        check_value("midrst_hi",   64'(hi32), 64'h0);
        check_value("midrst_lo",   64'(lo32), 64'h0);
        @(negedge clock);
        reset = 1'b1;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock); #1;
            if (done32) nd++;
        end
        check_value("postrst_ndone", 64'(nd), 64'd0);

        run8(2'b00, 8'h80, 8'h80, fd);
        check_value("w8_lat", 64'(fd), 64'd10);
        check_value("w8_hi",  64'(hi8), 64'h40);
        check_value("w8_lo",  64'(lo8), 64'h00);

        run8(2'b00, 8'h00, 8'h55, fd);
        check_value("w8zero_lat", 64'(fd), 64'(EXP_ZERO8_LAT));
        check_value("w8zero_hi",  64'(hi8), 64'h00);
        check_value("w8zero_lo",  64'(lo8), 64'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
